// File: rtl/rr_select_encoder_pkg.sv
// Shared constants, FSM state type and index helper for the round-robin select encoder.
// The encoded grant index feeds a 2-to-4 decoder as {s1,s0}.
package rr_sel_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Pointer value after reset, so that requester 0 is searched first.
  localparam logic [IDX_W-1:0] LAST_RST = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT   = ST_GRANT,
    RELEASE = ST_RELEASE
  } state_t;

  // Index arithmetic wraps naturally at IDX_W bits (3+1 = 0).
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base, input int off);
    return base + IDX_W'(off);
  endfunction

endpackage

// File: rtl/rr_select_encoder_if.sv
// Request/grant bundle between requesters (master side) and the arbiter (slave side).
interface rr_select_encoder_if;
  import rr_sel_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             preempt;
  logic             busy;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, preempt, busy
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, preempt, busy
  );

endinterface

// File: rtl/rr_select_encoder_pick.sv
// Rotate-priority search: first set request bit in order last_idx+1, +2, +3, +0.
module rr_pick
  import rr_sel_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             found,
  output logic [IDX_W-1:0] pick_idx
);

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[idx_add(last_idx, k)]) begin
        found    = 1'b1;
        pick_idx = idx_add(last_idx, k);
      end
    end
  end

endmodule

// File: rtl/rr_select_encoder.sv
// Four-requester round-robin arbiter with encoded grant index, tenure control
// (done, requester drop, hold timeout) and a one-cycle dead gap between grants.
module rr_select_encoder
  import rr_sel_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_select_encoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             gnt_valid_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             preempt_r;
  logic             busy_r;

  logic             found;
  logic [IDX_W-1:0] pick_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  rr_pick u_pick (
    .req      (bus.req),
    .last_idx (last_idx),
    .found    (found),
    .pick_idx (pick_idx)
  );

  // gnt_idx is only written on IDLE->GRANT so decoder inputs stay stable during a tenure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_idx    <= LAST_RST;
      hold_cnt    <= '0;
      gnt_valid_r <= 1'b0;
      gnt_idx_r   <= '0;
      preempt_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      preempt_r <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx_r   <= pick_idx;
            last_idx    <= pick_idx;
            gnt_valid_r <= 1'b1;
            hold_cnt    <= '0;
            busy_r      <= 1'b1;
            state       <= GRANT;
          end else begin
            gnt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end

        GRANT: begin
          hold_cnt <= sat_inc(hold_cnt);
          // done outranks timeout, so a coincident done suppresses the preempt pulse.
          if (bus.done || !bus.req[gnt_idx_r]) begin
            gnt_valid_r <= 1'b0;
            state       <= RELEASE;
          end else if (hold_cnt == HOLD_LAST) begin
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b1;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          gnt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          gnt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.preempt   = preempt_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/rr_select_encoder.md
Name: rr_select_encoder

Overview:
- Four-requester round-robin arbiter producing an encoded 2-bit grant index plus valid strobe.
- Sits directly upstream of the 2-to-4 decoder: gnt_idx[1] drives s1, gnt_idx[0] drives s0, and the decoder's one-hot outputs become the per-requester grant lines.
- Adds tenure control (done handshake, requester drop, hold-time timeout) and a one-cycle dead gap between grants.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may stay in GRANT before forced release; legal range 1..15.
- CNT_W, 4, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- req  input  4  request vector, bit i = requester i
- done  input  1  owner releases grant; sampled only in GRANT
- gnt_valid  output  1  grant active; gnt_idx meaningful
- gnt_idx  output  2  encoded owner index; feeds decoder {s1,s0}
- preempt  output  1  one-cycle pulse when a grant is ended by timeout
- busy  output  1  high in GRANT or RELEASE

Behaviour:
- Reset values: rst_n=0 sampled at an edge sets state=IDLE, gnt_valid=0, gnt_idx=2'b00, preempt=0, busy=0, last_idx=2'b11, hold_cnt=0. This applies even mid-grant, with no special drain.
- States: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - If req != 0, select the first set bit in rotate order last_idx+1, +2, +3, +0 (mod 4).
  - Register the winner into gnt_idx and last_idx; set gnt_valid=1 and hold_cnt=0; go to GRANT.
  - Latency: req seen at edge k gives gnt_valid=1 after edge k.
  - If req == 0, stay in IDLE; outputs unchanged except gnt_valid=0.
- GRANT: hold_cnt increments each cycle. Release conditions, in priority order:
  - (a) done=1 -> RELEASE, preempt=0.
  - (b) req[gnt_idx]=0 -> RELEASE, preempt=0.
  - (c) hold_cnt == MAX_HOLD-1 -> RELEASE, preempt=1 for exactly the next cycle.
  - If done and timeout coincide, done wins and no preempt pulse is issued.
- RELEASE:
  - gnt_valid=0; gnt_idx holds the last owner; busy=1.
  - Unconditionally go to IDLE next edge.
  - Earliest next grant: gnt_valid re-asserts 2 cycles after it dropped.
- Hold-time bound: gnt_valid is high for at most MAX_HOLD consecutive cycles.
- gnt_idx changes only on IDLE->GRANT transitions, so decoder inputs never glitch during a grant.
- Requests arriving or changing in GRANT/RELEASE do not alter the current owner.
- Fairness: a continuously requesting agent waits at most 3 grants.
- Arithmetic: all index math is 2-bit with natural wrap (3+1=0). hold_cnt saturates; it never wraps in GRANT.

Decomposition:
- Shared package rr_sel_pkg holds:
  - N_REQ=4, IDX_W=2.
  - State localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
  - Reset pointer constant LAST_RST=2'b11.
- One combinational sub-module, rr_pick:
  - Inputs: req[3:0], last_idx[1:0].
  - Outputs: found, pick_idx[1:0].
  - Implements the rotate-priority search.
- The top module holds the FSM, hold counter, and registers.

Test Plan:
- Reset then req=4'b1111, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,3,0; gnt_valid pattern 1,0,0 between grants (RELEASE + IDLE gap).
- req=4'b0100 held, done never -> gnt_idx=2; gnt_valid high exactly 8 cycles; preempt pulses once the cycle after drop; regrant of 2 follows 2 cycles later.
- Grant to idx 1, then drop req[1] mid-grant -> next cycle gnt_valid=0, preempt=0, state RELEASE.
- done=1 on the same cycle hold_cnt=MAX_HOLD-1 -> release with preempt=0.
- Grant to idx 3 active, assert rst_n=0 for one edge -> after that edge gnt_valid=0, gnt_idx=0, busy=0; then req=4'b1001 -> grant idx 0 (pointer reset to 3).
- Decoder hookup: connect the decoder with s1=gnt_idx[1], s0=gnt_idx[0], requests 0..3 granted in turn -> decoder outputs o0..o3 one-hot in turn, gated by gnt_valid.
